// File: rtl/lynxTypes.sv
// Shared types and sizing for the RDMA command path.
//   N_REGIONS     : number of vFPGA regions issuing commands
//   N_OUTSTANDING : read commands a region may have in flight
//   req_t         : one read command as carried on the request streams
package lynxTypes;

    localparam int N_REGIONS     = 4;
    localparam int N_OUTSTANDING = 8;

    typedef struct packed {
        logic [47:0] vaddr;
        logic [27:0] len;
        logic [5:0]  pid;
    } req_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Cyclic first-one search used by the read-command arbiter.
//   eligible : requesters that may be granted this cycle
//   ptr      : index where the search starts
//   idx      : first eligible index at or after ptr, wrapping around
//   found    : at least one requester was eligible
module arb_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           found
);

    // Two linear passes instead of a modulo walk: the first covers
    // ptr..N-1, the second picks up the wrapped range 0..ptr-1.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && eligible[j] && (j >= 32'(ptr))) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && eligible[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/rdma_arb_cmd_rd.sv
// Round-robin arbiter for RDMA read commands with per-region credit limits.
// Each region may have at most N_CRED commands in flight; a completion
// (cpl_valid/cpl_id) returns one credit.
//   aclk, areset            : clock, synchronous active-high reset
//   s_req_valid/ready/data  : per-region command streams
//   m_req_valid/ready/data  : arbitrated command (registered)
//   m_req_id                : region that owns m_req_data
//   cpl_valid, cpl_id       : one transfer finished for region cpl_id
//   idle                    : no credits out and output register empty
//   err                     : sticky, completion without a matching credit
module rdma_arb_cmd_rd
    import lynxTypes::*;
#(
    parameter  int N_REQ   = N_REGIONS,
    parameter  int N_CRED  = N_OUTSTANDING,
    localparam int ID_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [N_REQ-1:0]     s_req_valid,
    output logic [N_REQ-1:0]     s_req_ready,
    input  req_t [N_REQ-1:0]     s_req_data,
    output logic                 m_req_valid,
    input  logic                 m_req_ready,
    output req_t                 m_req_data,
    output logic [ID_BITS-1:0]   m_req_id,
    input  logic                 cpl_valid,
    input  logic [ID_BITS-1:0]   cpl_id,
    output logic                 idle,
    output logic                 err
);

    localparam int CNT_W = $clog2(N_CRED + 1);

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   dec;
    logic [N_REQ-1:0]   busy_nxt;
    logic [ID_BITS-1:0] rr_ptr;
    logic [ID_BITS-1:0] win;
    logic               found;
    logic               grant;
    logic               mvalid_nxt;
    logic               cpl_hit;

    arb_rr_pick #(
        .N   (N_REQ),
        .IDW (ID_BITS)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .idx      (win),
        .found    (found)
    );

    // A grant may land while the held command drains, keeping one per cycle.
    assign grant      = !areset && found && (!m_req_valid || m_req_ready);
    assign mvalid_nxt = grant || (m_req_valid && !m_req_ready);

    always_comb begin
        s_req_ready = '0;
        if (grant) begin
            s_req_ready[win] = 1'b1;
        end
    end

    genvar g;
    for (g = 0; g < N_REQ; g++) begin : g_cred
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             inc;

        // Eligibility looks at the registered count, so a credit returned
        // this cycle is only usable next cycle.
        assign eligible[g] = s_req_valid[g] && (cnt_q < CNT_W'(N_CRED));
        assign inc         = grant && (win == ID_BITS'(g));
        assign dec[g]      = cpl_valid && (cpl_id == ID_BITS'(g)) && (cnt_q != '0);

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec[g]) begin
                cnt_d = cnt_q + 1'b1;
            end else if (dec[g] && !inc) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        assign busy_nxt[g] = (cnt_d != '0);

        always_ff @(posedge aclk) begin
            if (areset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Out-of-range ids and zero counters both leave dec clear.
    assign cpl_hit = |dec;

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_req_valid <= 1'b0;
            m_req_id    <= '0;
            m_req_data  <= '0;
            rr_ptr      <= '0;
            err         <= 1'b0;
            idle        <= 1'b1;
        end else begin
            m_req_valid <= mvalid_nxt;
            if (grant) begin
                m_req_data <= s_req_data[win];
                m_req_id   <= win;
                rr_ptr     <= (win == ID_BITS'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (cpl_valid && !cpl_hit) begin
                err <= 1'b1;
            end
            idle <= !(|busy_nxt) && !mvalid_nxt;
        end
    end

endmodule

// File: tb/tb_rdma_arb_cmd_rd.sv
// Self-checking bench for rdma_arb_cmd_rd (4 regions, 2 credits each).
module tb_rdma_arb_cmd_rd;
    import lynxTypes::*;

    localparam int NR = 4;
    localparam int NC = 2;

    logic       aclk = 1'b0;
    logic       areset;
    logic [3:0] s_req_valid;
    logic [3:0] s_req_ready;
    req_t [3:0] s_req_data;
    logic       m_req_valid;
    logic       m_req_ready;
    req_t       m_req_data;
    logic [1:0] m_req_id;
    logic       cpl_valid;
    logic [1:0] cpl_id;
    logic       idle;
    logic       err;

    rdma_arb_cmd_rd #(
        .N_REQ  (NR),
        .N_CRED (NC)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_data  (s_req_data),
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_data  (m_req_data),
        .m_req_id    (m_req_id),
        .cpl_valid   (cpl_valid),
        .cpl_id      (cpl_id),
        .idle        (idle),
        .err         (err)
    );

    always #5 aclk = ~aclk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: credits per region, round-robin start, output slot.
    int   cnt_m [NR];
    int   rr_m;
    bit   ov_m;
    int   oid_m;
    req_t od_m;
    bit   err_m;
    bit   idle_m;
    logic [3:0] rdy_m;
    logic [3:0] rdy_seen;

    task automatic model_reset();
        foreach (cnt_m[i]) cnt_m[i] = 0;
        rr_m = 0; ov_m = 0; oid_m = 0; od_m = '0; err_m = 0; idle_m = 1; rdy_m = '0;
    endtask

    task automatic model_step();
        int w;
        int j;
        int total;
        if (areset) begin
            model_reset();
        end else begin
            w = -1;
            if (!ov_m || m_req_ready) begin
                for (int k = 0; k < NR; k++) begin
                    j = (rr_m + k) % NR;
                    if (w < 0 && s_req_valid[j] && cnt_m[j] < NC) w = j;
                end
            end
            rdy_m = (w >= 0) ? 4'(1 << w) : 4'b0000;
            if (cpl_valid) begin
                if (cnt_m[cpl_id] > 0) cnt_m[cpl_id]--;
                else err_m = 1;
            end
            if (w >= 0) begin
                cnt_m[w]++;
                ov_m  = 1;
                oid_m = w;
                od_m  = s_req_data[w];
                rr_m  = (w + 1) % NR;
            end else if (m_req_ready) begin
                ov_m = 0;
            end
            total = 0;
            foreach (cnt_m[i]) total += cnt_m[i];
            idle_m = (total == 0) && !ov_m;
        end
    endtask

    function automatic req_t rnd_req();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return req_t'(r[$bits(req_t)-1:0]);
    endfunction

    // One clock: fresh data, compare combinational ready, then registered outputs.
    task automatic cycle();
        for (int i = 0; i < NR; i++) s_req_data[i] = rnd_req();
        #2;
        model_step();
        rdy_seen = s_req_ready;
        check("s_req_ready", s_req_ready, rdy_m);
        @(posedge aclk);
        #1;
        check("m_req_valid", m_req_valid, ov_m);
        check("m_req_id", m_req_id, oid_m);
        check("m_req_data", m_req_data, od_m);
        check("idle", idle, idle_m);
        check("err", err, err_m);
    endtask

    task automatic do_reset();
        areset = 1'b1; s_req_valid = '0; m_req_ready = 1'b1; cpl_valid = 1'b0; cpl_id = '0;
        cycle();
        areset = 1'b0;
    endtask

    int fair [6] = '{0, 1, 2, 3, 0, 1};
    int grants;
    req_t held;

    initial begin
        model_reset();
        areset = 1'b1; s_req_valid = '0; m_req_ready = 1'b1; cpl_valid = 1'b0; cpl_id = '0;
        cycle();
        do_reset();

        // Fairness: everyone valid, sink always ready.
        s_req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("fair_id", m_req_id, fair[i]);
            check("fair_valid", m_req_valid, 1'b1);
        end

        // Reset with a command pending.
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        s_req_valid = '0;
        check("rst_valid", m_req_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_idle", idle, 1'b1);

        // Completion against an empty counter.
        cpl_valid = 1'b1; cpl_id = 2'd3;
        cycle();
        cpl_valid = 1'b0;
        check("err_set", err, 1'b1);
        s_req_valid = 4'b1000;
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            grants += int'(rdy_seen[3]);
        end
        check("err_no_cnt_change", grants, 2);
        check("err_sticky", err, 1'b1);
        do_reset();

        // Credit exhaustion on region 2.
        s_req_valid = 4'b0100;
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            grants += int'(rdy_seen[2]);
        end
        check("exhaust_grants", grants, 2);
        check("exhaust_hold", rdy_seen, 4'b0000);
        cpl_valid = 1'b1; cpl_id = 2'd2;
        cycle();
        cpl_valid = 1'b0;
        check("cpl_cycle_rdy", rdy_seen[2], 1'b0);
        cycle();
        check("regrant", rdy_seen[2], 1'b1);
        grants = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            grants += int'(rdy_seen[2]);
        end
        check("regrant_once", grants, 0);
        do_reset();

        // Backpressure.
        s_req_valid = 4'b0011; m_req_ready = 1'b0;
        cycle();
        check("bp_first_id", m_req_id, 2'd0);
        held = m_req_data;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_rdy", rdy_seen, 4'b0000);
            check("bp_data", m_req_data, held);
            check("bp_id", m_req_id, 2'd0);
        end
        m_req_ready = 1'b1;
        cycle();
        check("bp_release_rdy", rdy_seen, 4'b0010);
        check("bp_next_id", m_req_id, 2'd1);
        do_reset();

        // Grant and completion to the same region in one cycle.
        s_req_valid = 4'b0010;
        cycle();
        cpl_valid = 1'b1; cpl_id = 2'd1;
        cycle();
        cpl_valid = 1'b0;
        check("sim_grant", rdy_seen, 4'b0010);
        check("sim_err", err, 1'b0);
        grants = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            grants += int'(rdy_seen[1]);
        end
        check("sim_cnt_left", grants, 1);
        do_reset();

        // Saturated region 0 must not block region 3 when the search starts at 0.
        s_req_valid = 4'b0001;
        cycle();
        cycle();
        s_req_valid = 4'b1000;
        cycle();
        s_req_valid = 4'b1001;
        cycle();
        check("skip_rdy", rdy_seen, 4'b1000);
        check("skip_id", m_req_id, 2'd3);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            areset      = ($urandom_range(0, 49) == 0);
            s_req_valid = 4'($urandom);
            m_req_ready = ($urandom_range(0, 9) < 7);
            cpl_valid   = ($urandom_range(0, 3) == 0);
            cpl_id      = 2'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
